// File: rtl/led_pkg.sv
// Shared types and defaults for the LED bar serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } led_state_t;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } led_phase_t;

    localparam int LED_WIDTH = 16;
    localparam int SCLK_DIV  = 2;

endpackage

// File: rtl/div_tick.sv
// Divider: tick pulses for one cycle every CLK_DIV enabled cycles.
// Latency: tick is combinational from the count register; clr takes effect next edge.
// Backpressure: none; the count freezes while en is low.
//   clk, rst : clock, synchronous active-high reset
//   en       : count enable
//   clr      : synchronous clear (wins over en)
//   tick     : high on the last cycle of each CLK_DIV-cycle period
module div_tick
    import led_pkg::*;
#(
    parameter int CLK_DIV = SCLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Wrapping to zero on tick means every phase change also restarts the count.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_shift_out.sv
// Serializes a parallel frame MSB-first onto sclk/sdata for a 74HC595 chain, then pulses latch.
// Latency: outputs registered; first bit valid the cycle after the strobe, transfer lasts 2*D*WIDTH + D cycles.
// Backpressure: none upstream; one-deep pending buffer (newest wins), sticky overrun when a pending frame is lost.
//   clk, rst    : clock, synchronous active-high reset
//   frame_in    : frame to display, sampled when frame_valid = 1
//   frame_valid : one-cycle new-frame strobe
//   sclk, sdata : serial clock / data to the register chain
//   latch       : storage-register latch pulse
//   busy        : transfer in progress (SHIFT or LATCH)
//   overrun     : sticky, a pending frame was overwritten
module led_shift_out
    import led_pkg::*;
#(
    parameter int WIDTH   = LED_WIDTH,
    parameter int CLK_DIV = SCLK_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] frame_in,
    input  logic             frame_valid,
    output logic             sclk,
    output logic             sdata,
    output logic             latch,
    output logic             busy,
    output logic             overrun
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    led_state_t       state_q, state_d;
    led_phase_t       phase_q, phase_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic             overrun_d;
    logic             sclk_d, sdata_d, latch_d, busy_d;
    logic             tick;
    logic             last_latch;

    div_tick #(.CLK_DIV(CLK_DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != ST_IDLE),
        .clr  (state_q == ST_IDLE),
        .tick (tick)
    );

    assign last_latch = (state_q == ST_LATCH) && tick;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        overrun_d   = overrun;

        case (state_q)
            ST_IDLE: begin
                if (frame_valid) begin
                    state_d = ST_SHIFT;
                    phase_d = PH_LOW;
                    bit_d   = '0;
                    sh_d    = frame_in;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (phase_q == PH_LOW) begin
                        phase_d = PH_HIGH;
                    end else if (bit_q == LAST_BIT) begin
                        state_d = ST_LATCH;
                    end else begin
                        phase_d = PH_LOW;
                        bit_d   = bit_q + 1'b1;
                        sh_d    = sh_q << 1;
                    end
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    // A strobe in the final latch cycle is newer than anything pending.
                    if (frame_valid || pend_full_q) begin
                        state_d     = ST_SHIFT;
                        phase_d     = PH_LOW;
                        bit_d       = '0;
                        sh_d        = frame_valid ? frame_in : pend_q;
                        pend_full_d = 1'b0;
                        if (frame_valid && pend_full_q) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Mid-transfer strobes go to the pending slot; the final latch cycle is handled above.
        if (frame_valid && (state_q != ST_IDLE) && !last_latch) begin
            pend_d      = frame_in;
            pend_full_d = 1'b1;
            if (pend_full_q) begin
                overrun_d = 1'b1;
            end
        end

        // Outputs are decoded from the next state so they come straight off flops.
        busy_d  = (state_d != ST_IDLE);
        latch_d = (state_d == ST_LATCH);
        sclk_d  = (state_d == ST_SHIFT) && (phase_d == PH_HIGH);
        sdata_d = (state_d == ST_SHIFT) ? sh_d[WIDTH-1] : sdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_LOW;
            bit_q       <= '0;
            sh_q        <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            overrun     <= 1'b0;
            sclk        <= 1'b0;
            sdata       <= 1'b0;
            latch       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            overrun     <= overrun_d;
            sclk        <= sclk_d;
            sdata       <= sdata_d;
            latch       <= latch_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_led_shift_out.sv
module tb_led_shift_out;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] frame_in = '0;
    logic        frame_valid = 1'b0;
    logic        sclk, sdata, latch, busy, overrun;

    led_shift_out #(.WIDTH(16), .CLK_DIV(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .sclk        (sclk),
        .sdata       (sdata),
        .latch       (latch),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Per-cycle stimulus schedule and recorded outputs (index = cycle number).
    logic [15:0] sched_f [0:199];
    logic        sched_v [0:199];
    logic        sched_r [0:199];
    logic        rec_sclk [0:199];
    logic        rec_sdata [0:199];
    logic        rec_latch [0:199];
    logic        rec_busy [0:199];
    logic        rec_ovr [0:199];

    // Model of the external 74HC595 chain.
    logic [15:0] ext_sr;
    logic [15:0] last_latched;
    int          n_rise;
    int          n_latch;
    int          rise_cyc [0:63];

    typedef struct {
        logic [15:0] f0;
        int          t1;
        logic [15:0] f1;
        int          t2;
        logic [15:0] f2;
        int          ncyc;
        logic [15:0] exp_val;
        int          exp_latch;
        int          exp_rise;
        int          exp_ovr;
    } vec_t;

    vec_t vecs [0:6];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 200; i++) begin
            sched_f[i] = '0;
            sched_v[i] = 1'b0;
            sched_r[i] = 1'b0;
        end
    endtask

    task automatic run(input int ncyc);
        ext_sr       = '0;
        last_latched = '0;
        n_rise       = 0;
        n_latch      = 0;
        for (int i = 0; i < 64; i++) rise_cyc[i] = -1;
        rec_sclk[0]  = sclk;
        rec_sdata[0] = sdata;
        rec_latch[0] = latch;
        rec_busy[0]  = busy;
        rec_ovr[0]   = overrun;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            frame_valid = sched_v[c];
            frame_in    = sched_f[c];
            rst         = sched_r[c];
            @(posedge clk);
            #1;
            rec_sclk[c+1]  = sclk;
            rec_sdata[c+1] = sdata;
            rec_latch[c+1] = latch;
            rec_busy[c+1]  = busy;
            rec_ovr[c+1]   = overrun;
            if (!rec_sclk[c] && rec_sclk[c+1]) begin
                ext_sr = {ext_sr[14:0], sdata};
                if (n_rise < 64) rise_cyc[n_rise] = c + 1;
                n_rise++;
            end
            if (!rec_latch[c] && rec_latch[c+1]) begin
                last_latched = ext_sr;
                n_latch++;
            end
        end
        @(negedge clk);
        frame_valid = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic do_reset();
        clear_sched();
        sched_r[0] = 1'b1;
        sched_r[1] = 1'b1;
        run(3);
        clear_sched();
    endtask

    initial begin
        int bad;
        int first_bad;

        vecs[0] = '{16'hA5F0, -1, 16'h0000, -1, 16'h0000,  70, 16'hA5F0, 1, 16, 0};
        vecs[1] = '{16'hFFFF, 20, 16'h0001, -1, 16'h0000, 140, 16'h0001, 2, 32, 0};
        vecs[2] = '{16'h8000, 10, 16'h4000, 30, 16'h2000, 140, 16'h2000, 2, 32, 1};
        vecs[3] = '{16'h00FF, 66, 16'h1234, -1, 16'h0000, 140, 16'h1234, 2, 32, 0};
        vecs[4] = '{16'h0000, -1, 16'h0000, -1, 16'h0000,  70, 16'h0000, 1, 16, 0};
        vecs[5] = '{16'h8001, -1, 16'h0000, -1, 16'h0000,  70, 16'h8001, 1, 16, 0};
        vecs[6] = '{16'hC3A5,  5, 16'h5A3C, -1, 16'h0000, 140, 16'h5A3C, 2, 32, 0};

        // Reset with no strobes: all outputs stay low, no sclk edges.
        clear_sched();
        sched_r[0] = 1'b1;
        run(10);
        bad = 0;
        for (int c = 1; c <= 10; c++) begin
            if (rec_sclk[c] || rec_sdata[c] || rec_latch[c] || rec_busy[c] || rec_ovr[c]) bad++;
        end
        chk("reset_idle_nonzero_cycles", bad, 0);
        chk("reset_idle_sclk_rises", n_rise, 0);

        // Table-driven transfers.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            sched_v[0] = 1'b1;
            sched_f[0] = vecs[v].f0;
            if (vecs[v].t1 >= 0) begin
                sched_v[vecs[v].t1] = 1'b1;
                sched_f[vecs[v].t1] = vecs[v].f1;
            end
            if (vecs[v].t2 >= 0) begin
                sched_v[vecs[v].t2] = 1'b1;
                sched_f[vecs[v].t2] = vecs[v].f2;
            end
            run(vecs[v].ncyc);
            chk($sformatf("vec%0d_latched_value", v), int'(last_latched), int'(vecs[v].exp_val));
            chk($sformatf("vec%0d_latch_pulses", v), n_latch, vecs[v].exp_latch);
            chk($sformatf("vec%0d_sclk_rises", v), n_rise, vecs[v].exp_rise);
            chk($sformatf("vec%0d_overrun", v), int'(rec_ovr[vecs[v].ncyc]), vecs[v].exp_ovr);
            chk($sformatf("vec%0d_busy_end", v), int'(rec_busy[vecs[v].ncyc]), 0);
        end

        // Single frame detailed timing: rises at 3+4k, latch 65-66, busy 1-66.
        do_reset();
        sched_v[0] = 1'b1;
        sched_f[0] = 16'hA5F0;
        run(70);
        chk("single_first_sdata", int'(rec_sdata[1]), 1);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("single_rise_cycle_bit%0d", k), rise_cyc[k], 3 + 4 * k);
        end
        bad = 0;
        first_bad = -1;
        for (int c = 1; c <= 70; c++) begin
            if (rec_latch[c] != ((c == 65) || (c == 66))) begin
                bad++;
                if (first_bad < 0) first_bad = c;
            end
        end
        chk("single_latch_window_bad_cycles", bad, 0);
        bad = 0;
        for (int c = 1; c <= 70; c++) begin
            if (rec_busy[c] != ((c >= 1) && (c <= 66))) begin
                bad++;
                if (first_bad < 0) first_bad = c;
            end
        end
        chk("single_busy_window_bad_cycles", bad, 0);
        chk("single_busy_low_at_67", int'(rec_busy[67]), 0);

        // Chained transfer: busy never drops, second bit 0 low phase starts at 67.
        do_reset();
        sched_v[0]  = 1'b1;
        sched_f[0]  = 16'hFFFF;
        sched_v[20] = 1'b1;
        sched_f[20] = 16'h0001;
        run(140);
        bad = 0;
        for (int c = 1; c <= 132; c++) if (!rec_busy[c]) bad++;
        chk("chain_busy_gap_cycles", bad, 0);
        chk("chain_busy_low_at_133", int'(rec_busy[133]), 0);
        chk("chain_sclk_low_at_67", int'(rec_sclk[67]), 0);
        chk("chain_second_rise_cycle", rise_cyc[16], 69);
        chk("chain_second_latch_start", int'(rec_latch[131]), 1);
        chk("chain_overrun", int'(rec_ovr[139]), 0);

        // Three strobes: overrun sets at cycle 31 and stays.
        do_reset();
        sched_v[0]  = 1'b1;
        sched_f[0]  = 16'h8000;
        sched_v[10] = 1'b1;
        sched_f[10] = 16'h4000;
        sched_v[30] = 1'b1;
        sched_f[30] = 16'h2000;
        run(140);
        chk("ovr_low_at_30", int'(rec_ovr[30]), 0);
        bad = 0;
        for (int c = 31; c <= 140; c++) if (!rec_ovr[c]) bad++;
        chk("ovr_sticky_cleared_cycles", bad, 0);
        chk("ovr_second_frame", int'(last_latched), 16'h2000);

        // Reset mid-shift at cycle 30, new strobe at 40.
        do_reset();
        sched_v[0]  = 1'b1;
        sched_f[0]  = 16'hA5F0;
        sched_r[30] = 1'b1;
        sched_v[40] = 1'b1;
        sched_f[40] = 16'h3C3C;
        run(120);
        chk("rst_outputs_at_31",
            int'({rec_sclk[31], rec_sdata[31], rec_latch[31], rec_busy[31], rec_ovr[31]}), 0);
        bad = 0;
        for (int c = 1; c <= 104; c++) if (rec_latch[c]) bad++;
        chk("rst_no_early_latch_cycles", bad, 0);
        chk("rst_busy_at_41", int'(rec_busy[41]), 1);
        chk("rst_latch_at_105", int'(rec_latch[105]), 1);
        chk("rst_latch_pulses", n_latch, 1);
        chk("rst_new_frame", int'(last_latched), 16'h3C3C);

        // Strobe exactly in the last latch cycle.
        do_reset();
        sched_v[0]  = 1'b1;
        sched_f[0]  = 16'h00FF;
        sched_v[66] = 1'b1;
        sched_f[66] = 16'h1234;
        run(140);
        chk("edge_busy_at_67", int'(rec_busy[67]), 1);
        chk("edge_sdata_at_67", int'(rec_sdata[67]), 0);
        chk("edge_second_rise_cycle", rise_cyc[16], 69);
        chk("edge_frame", int'(last_latched), 16'h1234);
        chk("edge_overrun", int'(rec_ovr[139]), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_shift_out.md
# led_shift_out

Serializer between the frame generator and the external 74HC595-style shift-register chain driving the LED bar. It accepts a parallel frame on a one-cycle strobe (the generator's frame-change pulse), shifts it out MSB-first on `sdata`/`sclk`, then pulses `latch` so all LEDs update at once. A one-deep pending buffer absorbs frames that arrive mid-transfer, and a sticky flag records frames that are lost.

## Interface
- `WIDTH`, 16: frame width in bits, equal to the number of chained register outputs.
- `CLK_DIV`, 2: system clocks per half serial-clock period (D); must be ≥ 1.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, synchronous, active-high.
- `frame_in`  in  WIDTH: frame to display; sampled only when `frame_valid` = 1.
- `frame_valid`  in  1: one-cycle strobe; a new frame is available.
- `sclk`  out  1: serial clock; the register samples on its rising edge.
- `sdata`  out  1: serial data, MSB first.
- `latch`  out  1: storage-register latch pulse.
- `busy`  out  1: a transfer is in progress (SHIFT or LATCH).
- `overrun`  out  1: sticky; a pending frame was overwritten. Only `rst` clears it.

## Operation
- All outputs are registered. After reset: `sclk`=0, `sdata`=0, `latch`=0, `busy`=0, `overrun`=0, shift register=0, pending buffer empty.
- FSM states:
  - IDLE.
  - SHIFT: bit counter 0..WIDTH-1, phase LOW/HIGH.
  - LATCH.
- IDLE, `frame_valid`=1: load `frame_in` into the shift register and go to SHIFT, bit 0, phase LOW.
- SHIFT, each bit:
  - `sdata` = current MSB and `sclk`=0 for D cycles.
  - Then `sclk`=1 for D cycles, with `sdata` held.
  - Then shift left by one and increment the bit counter.
  - After bit WIDTH-1 in the HIGH phase, go to LATCH.
- LATCH: `latch`=1, `sclk`=0, `sdata` holds the last bit, for D cycles. Then:
  - go to IDLE if nothing is pending;
  - otherwise start the next transfer directly.
- `frame_valid` while `busy`: store `frame_in` in the pending buffer; the newest frame wins. If the buffer was already full, set `overrun`.
- `frame_valid` in the final LATCH cycle: treated as pending, overriding any older pending frame (sets `overrun` if one existed). The next transfer starts the following cycle with the newest frame.
- `frame_valid` while IDLE and pending empty: start immediately; no buffering.
- `rst` mid-transfer: abort at once; every output and all state return to reset values on the next edge. No partial latch pulse.
- The divider counter runs only in SHIFT and LATCH and is cleared on every phase change.

## Timing
- Strobe accepted at edge 0. `busy`=1 and the first `sdata` bit are valid from cycle 1.
- Rising `sclk` edge for bit k occurs at cycle 1 + D + 2Dk.
- `latch` is high for cycles 2D·WIDTH+1 through 2D·WIDTH+D.
- `busy` stays high for 2D·WIDTH + D cycles and deasserts the cycle after the last latch cycle, unless a pending frame chains in.
- Back-to-back chained transfers: `busy` stays 1; `sclk` LOW phase of bit 0 begins the cycle after the last latch cycle.
- Setup and hold at the external register are guaranteed by construction: `sdata` is stable D cycles before and D cycles after each rising `sclk`.

## Structure
- Shared package `led_pkg`:
  - FSM state enum (IDLE/SHIFT/LATCH);
  - default `LED_WIDTH` = 16;
  - default `SCLK_DIV`.
- Sub-module `div_tick`: a counter that pulses one cycle every `CLK_DIV` cycles while enabled and clears synchronously. The FSM, shift register and pending buffer stay in `led_shift_out`.

## Test plan
All scenarios use WIDTH=16, D=2.
- Reset with `frame_valid` held 0 → all outputs 0 for 10 cycles; no `sclk` edges.
- Single frame 16'hA5F0 at cycle 0:
  - 16 rising `sclk` edges at cycles 3, 7, …, 63;
  - sampled bits 1010_0101_1111_0000;
  - `latch` high cycles 65–66;
  - `busy` high cycles 1–66, low at 67.
- Frame 16'hFFFF, then 16'h0001 strobed at cycle 20 → second transfer starts at cycle 67 without `busy` dropping; second latched value is 16'h0001; `overrun`=0.
- Three strobes (16'h8000, 16'h4000 at cycle 10, 16'h2000 at cycle 30) → second transfer shifts 16'h2000; `overrun`=1 from cycle 31 and stays set.
- `rst` asserted at cycle 30 mid-shift → all outputs 0 at cycle 31; no `latch` pulse; a new strobe at cycle 40 runs a full, correct transfer.
- Strobe 16'h1234 exactly at cycle 66 (last latch cycle) → next transfer begins at cycle 67, shifts 16'h1234; `overrun`=0.
